// File: rtl/count_pkg.sv
// Shared definitions for the count sequence checker, the upstream counter and their benches:
// checker state encoding and default width constants.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_STAT_W      = 8;
  localparam int DEF_LOCK_THRESH = 3;
  localparam int GOOD_RUN_W      = 4;

endpackage

// File: rtl/count_seq_checker_if.sv
// Bus between a count source and the sequence checker.
// The master drives enable/clear/count and the slave returns status and statistics.
interface count_seq_checker_if #(
  parameter int WIDTH  = 4,
  parameter int STAT_W = 8
) ();
  logic              en;
  logic              clear;
  logic [WIDTH-1:0]  count;
  logic              locked;
  logic              wrap_pulse;
  logic              err_pulse;
  logic              err_sticky;
  logic [WIDTH-1:0]  err_expected;
  logic [WIDTH-1:0]  err_actual;
  logic [STAT_W-1:0] wrap_cnt;
  logic [STAT_W-1:0] err_cnt;

  modport master (
    output en, clear, count,
    input  locked, wrap_pulse, err_pulse, err_sticky,
    input  err_expected, err_actual, wrap_cnt, err_cnt
  );

  modport slave (
    input  en, clear, count,
    output locked, wrap_pulse, err_pulse, err_sticky,
    output err_expected, err_actual, wrap_cnt, err_cnt
  );
endinterface

// File: rtl/count_seq_checker_sat_counter.sv
// Saturating statistics counter; a clear and an increment in the same cycle yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);
  logic [W-1:0] r_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= '0;
    end else if (clr) begin
      r_value <= inc ? W'(1) : '0;
    end else if (inc && (r_value != '1)) begin
      r_value <= r_value + W'(1);
    end
  end

  assign value = r_value;
endmodule

// File: rtl/count_seq_checker.sv
// Checks that the sampled count advances by one each clock (mod 2^WIDTH).
// Optional: define COUNT_SEQ_HOLD_EN to accept count == prev in TRACK as a stall.
module count_seq_checker
  import count_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int STAT_W      = DEF_STAT_W,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH
) (
  input logic               clk,
  input logic               reset,
  count_seq_checker_if.slave bus
);
  localparam logic [GOOD_RUN_W-1:0] LT = GOOD_RUN_W'(LOCK_THRESH);

  state_t                r_state, w_state_n;
  logic [WIDTH-1:0]      r_prev, w_prev_n;
  logic [GOOD_RUN_W-1:0] r_good, w_good_n;
  logic                  r_locked, w_locked_n;
  logic                  r_wrap_pulse, w_wrap_pulse_n;
  logic                  r_err_pulse, w_err_pulse_n;
  logic                  r_sticky, w_sticky_n;
  logic [WIDTH-1:0]      r_err_exp, w_err_exp_n;
  logic [WIDTH-1:0]      r_err_act, w_err_act_n;
  logic                  w_wrap_inc, w_err_inc;
  logic [WIDTH-1:0]      w_expected;
  logic                  w_match, w_hold;
  logic [STAT_W-1:0]     w_wrap_cnt, w_err_cnt;

  assign w_expected = r_prev + WIDTH'(1);
  assign w_match    = (bus.count == w_expected);
`ifdef COUNT_SEQ_HOLD_EN
  assign w_hold     = (bus.count == r_prev);
`else
  assign w_hold     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_good       <= '0;
      r_locked     <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_sticky     <= 1'b0;
      r_err_exp    <= '0;
      r_err_act    <= '0;
    end else begin
      r_state      <= w_state_n;
      r_prev       <= w_prev_n;
      r_good       <= w_good_n;
      r_locked     <= w_locked_n;
      r_wrap_pulse <= w_wrap_pulse_n;
      r_err_pulse  <= w_err_pulse_n;
      r_sticky     <= w_sticky_n;
      r_err_exp    <= w_err_exp_n;
      r_err_act    <= w_err_act_n;
    end
  end

  // Clear is folded into the defaults so a same-cycle event is recorded on top of it.
  always_comb begin
    w_state_n      = r_state;
    w_prev_n       = r_prev;
    w_good_n       = r_good;
    w_wrap_pulse_n = 1'b0;
    w_err_pulse_n  = 1'b0;
    w_wrap_inc     = 1'b0;
    w_err_inc      = 1'b0;
    w_sticky_n     = bus.clear ? 1'b0 : r_sticky;
    w_err_exp_n    = bus.clear ? '0 : r_err_exp;
    w_err_act_n    = bus.clear ? '0 : r_err_act;

    if (!bus.en) begin
      w_state_n = IDLE;
      w_good_n  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_prev_n  = bus.count;
          w_good_n  = '0;
          w_state_n = SYNC;
        end
        SYNC: begin
          w_prev_n = bus.count;
          if (w_match) begin
            w_state_n = TRACK;
            w_good_n  = GOOD_RUN_W'(1);
          end else begin
            w_good_n  = '0;
          end
        end
        TRACK: begin
          if (!w_hold) begin
            w_prev_n = bus.count;
            if (w_match) begin
              w_good_n = (r_good >= LT) ? LT : r_good + GOOD_RUN_W'(1);
              if (w_expected == '0) begin
                w_wrap_pulse_n = 1'b1;
                w_wrap_inc     = 1'b1;
              end
            end else begin
              w_err_pulse_n = 1'b1;
              w_err_inc     = 1'b1;
              w_good_n      = '0;
              if (!r_sticky || bus.clear) begin
                w_sticky_n  = 1'b1;
                w_err_exp_n = w_expected;
                w_err_act_n = bus.count;
              end
            end
          end
        end
        default: begin
          w_state_n = IDLE;
          w_good_n  = '0;
        end
      endcase
    end

    w_locked_n = (w_good_n >= LT);
  end

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (bus.clear),
    .inc   (w_wrap_inc),
    .value (w_wrap_cnt)
  );

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (reset),
    .clr   (bus.clear),
    .inc   (w_err_inc),
    .value (w_err_cnt)
  );

  assign bus.locked       = r_locked;
  assign bus.wrap_pulse   = r_wrap_pulse;
  assign bus.err_pulse    = r_err_pulse;
  assign bus.err_sticky   = r_sticky;
  assign bus.err_expected = r_err_exp;
  assign bus.err_actual   = r_err_act;
  assign bus.wrap_cnt     = w_wrap_cnt;
  assign bus.err_cnt      = w_err_cnt;
endmodule

// File: tb/tb_count_seq_checker.sv
// Self-checking bench for count_seq_checker against a rule-level reference model.
module tb_count_seq_checker;
  localparam int WIDTH = 4;
  localparam int STAT_W = 8;
  localparam int MOD = 16;
  localparam int SMAX = 255;
  localparam int THRESH = 3;
`ifdef COUNT_SEQ_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  count_seq_checker_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus ();

  count_seq_checker #(.WIDTH(WIDTH), .STAT_W(STAT_W), .LOCK_THRESH(THRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cur = 0;

  // Reference model: plain arithmetic over the sampled sequence.
  bit m_have, m_sync, m_wp, m_ep, m_sticky;
  int m_prev, m_run, m_exp, m_act, m_wc, m_ec;

  function automatic logic [27:0] model_vec();
    return {m_run >= THRESH, m_wp, m_ep, m_sticky, 4'(m_exp), 4'(m_act), 8'(m_wc), 8'(m_ec)};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {bus.locked, bus.wrap_pulse, bus.err_pulse, bus.err_sticky,
            bus.err_expected, bus.err_actual, bus.wrap_cnt, bus.err_cnt};
  endfunction

  task automatic model(input bit r, input bit e, input bit c, input int n);
    if (r) begin
      m_have = 0; m_sync = 0; m_run = 0; m_prev = 0; m_wp = 0; m_ep = 0;
      m_sticky = 0; m_exp = 0; m_act = 0; m_wc = 0; m_ec = 0;
      return;
    end
    m_wp = 0; m_ep = 0;
    if (c) begin m_wc = 0; m_ec = 0; m_sticky = 0; m_exp = 0; m_act = 0; end
    if (!e) begin
      m_have = 0; m_sync = 0; m_run = 0;
    end else if (!m_have) begin
      m_have = 1; m_prev = n; m_run = 0;
    end else if (!m_sync) begin
      if (n == (m_prev + 1) % MOD) begin m_sync = 1; m_run = 1; end
      else m_run = 0;
      m_prev = n;
    end else if (HOLD && n == m_prev) begin
      // stall: nothing changes
    end else if (n == (m_prev + 1) % MOD) begin
      m_run++;
      if (n == 0) begin m_wp = 1; if (m_wc < SMAX) m_wc++; end
      m_prev = n;
    end else begin
      m_ep = 1;
      if (m_ec < SMAX) m_ec++;
      m_run = 0;
      if (!m_sticky) begin m_sticky = 1; m_exp = (m_prev + 1) % MOD; m_act = n; end
      m_prev = n;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input int n);
    reset = r; bus.en = e; bus.clear = c; bus.count = WIDTH'(n);
    cur = n % MOD;
    @(posedge clk);
    model(r, e, c, n % MOD);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    n_vec++;
    if (dut_vec() !== 28'h0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", dut_vec(), 28'h0);
    end
  endtask

  task automatic test_lock_wrap();
    int wraps = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 0, i);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL lock_wrap[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
      if (bus.wrap_pulse === 1'b1) wraps++;
      if (i == 2 || i == 3) begin
        n_vec++;
        if (bus.locked !== (i == 3)) begin
          n_err++; $display("FAIL lock_edge[%0d]: got %b want %b", i, bus.locked, i == 3);
        end
      end
    end
    n_vec++;
    if (wraps != 2 || bus.wrap_cnt !== 8'd2 || bus.err_cnt !== 8'd0) begin
      n_err++; $display("FAIL wrap_total: pulses %0d wrap_cnt %0d err_cnt %0d want 2/2/0",
                        wraps, bus.wrap_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_error_capture();
    while (cur != 5) step(0, 1, 0, cur + 1);
    step(0, 1, 0, 9);
    n_vec++;
    if ({bus.err_pulse, bus.err_sticky, bus.locked, bus.err_expected, bus.err_actual, bus.err_cnt}
        !== {1'b1, 1'b1, 1'b0, 4'd6, 4'd9, 8'd1}) begin
      n_err++; $display("FAIL first_err: pulse %b sticky %b locked %b exp %0d act %0d cnt %0d want 1 1 0 6 9 1",
                        bus.err_pulse, bus.err_sticky, bus.locked, bus.err_expected, bus.err_actual, bus.err_cnt);
    end
    step(0, 1, 0, 10);
    n_vec++;
    if (bus.err_pulse !== 1'b0 || bus.err_cnt !== 8'd1) begin
      n_err++; $display("FAIL resync_good: pulse %b cnt %0d want 0 1", bus.err_pulse, bus.err_cnt);
    end
    step(0, 1, 0, 11);
    step(0, 1, 0, 12);
    step(0, 1, 0, 3);
    n_vec++;
    if ({bus.err_cnt, bus.err_expected, bus.err_actual} !== {8'd2, 4'd6, 4'd9}) begin
      n_err++; $display("FAIL second_err: cnt %0d exp %0d act %0d want 2 6 9",
                        bus.err_cnt, bus.err_expected, bus.err_actual);
    end
    step(0, 1, 0, 4);
    step(0, 1, 1, 8);
    n_vec++;
    if ({bus.err_cnt, bus.err_sticky, bus.err_expected, bus.err_actual} !== {8'd1, 1'b1, 4'd5, 4'd8}) begin
      n_err++; $display("FAIL clear_with_err: cnt %0d sticky %b exp %0d act %0d want 1 1 5 8",
                        bus.err_cnt, bus.err_sticky, bus.err_expected, bus.err_actual);
    end
    n_vec++;
    if (dut_vec() !== model_vec()) begin
      n_err++; $display("FAIL capture_model: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      step(0, 1, 0, cur + 2);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL saturate[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_vec++;
    if (bus.err_cnt !== 8'd255) begin
      n_err++; $display("FAIL err_cnt_sat: got %0d want 255", bus.err_cnt);
    end
  endtask

  task automatic test_reset_midrun();
    step(1, 1, 0, cur + 1);
    n_vec++;
    if (dut_vec() !== 28'h0) begin
      n_err++; $display("FAIL midrun_reset: got %h want %h", dut_vec(), 28'h0);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 5 + i);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL post_reset[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    n_vec++;
    if (bus.locked !== 1'b1) begin
      n_err++; $display("FAIL relock: got %b want 1", bus.locked);
    end
  endtask

  task automatic test_hold();
    step(0, 1, 1, cur + 1);
    step(0, 0, 0, 3);
    for (int i = 3; i <= 7; i++) step(0, 1, 0, i);
    step(0, 1, 0, 7);
    step(0, 1, 0, 7);
    n_vec++;
    if (bus.locked !== (HOLD ? 1'b1 : 1'b0)) begin
      n_err++; $display("FAIL hold_locked: got %b want %b", bus.locked, HOLD);
    end
    step(0, 1, 0, 8);
    n_vec++;
    if (bus.err_cnt !== (HOLD ? 8'd0 : 8'd2)) begin
      n_err++; $display("FAIL hold_errs: got %0d want %0d", bus.err_cnt, HOLD ? 0 : 2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      int sel, n;
      bit r, e, c;
      sel = $urandom_range(0, 99);
      if (sel < 70) n = cur + 1;
      else if (sel < 82) n = cur;
      else n = $urandom_range(0, MOD - 1);
      e = ($urandom_range(0, 19) != 0);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 149) == 0);
      step(r, e, c, n);
      n_vec++;
      if (dut_vec() !== model_vec()) begin
        n_err++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    bus.en = 1'b0; bus.clear = 1'b0; bus.count = '0;
    test_reset();
    test_lock_wrap();
    test_error_capture();
    test_saturate();
    test_reset_midrun();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Downstream consumer of the free-running up-counter's `count` bus.
- Samples the count every clock and checks that each value is the previous value plus one, modulo 2^WIDTH.
- Reports wrap events, sequence errors, lock status, saturating statistics and a capture of the first error.
- Used as an in-design monitor and as a self-checking companion in counter benches.

Parameters:
- WIDTH, 4, width of the monitored count bus.
- STAT_W, 8, width of the wrap and error statistic counters.
- LOCK_THRESH, 3, consecutive correct increments required before `locked` asserts (1..15).

Ports:
- clk  input  1  rising-edge clock, shared with the upstream counter.
- reset  input  1  synchronous, active-high reset.
- en  input  1  checking enable.
- clear  input  1  single-cycle pulse; clears statistics and sticky/capture state.
- count  input  WIDTH  upstream counter value.
- locked  output  1  sequence tracked for ≥ LOCK_THRESH consecutive good steps.
- wrap_pulse  output  1  one-cycle pulse on a correct (2^WIDTH−1)→0 step.
- err_pulse  output  1  one-cycle pulse on a sequence mismatch.
- err_sticky  output  1  set on the first error; held until `clear` or `reset`.
- err_expected  output  WIDTH  expected value at the first error.
- err_actual  output  WIDTH  observed value at the first error.
- wrap_cnt  output  STAT_W  saturating count of wraps.
- err_cnt  output  STAT_W  saturating count of errors.

Behaviour:
- Reset: synchronous and active-high. On the reset edge all outputs go to 0, the state machine goes to IDLE and the internal `prev` and `good_run` registers go to 0. Asserting reset mid-operation discards any in-progress tracking.
- All outputs are registered. An event detected on the sample taken at edge k is visible after edge k, i.e. one-cycle latency.
- States:
  - IDLE: when `en` = 1, capture `prev` = count and move to SYNC.
  - SYNC: compare the next sample with `prev`+1.
    - Match: move to TRACK with `good_run` = 1.
    - Mismatch: stay in SYNC with `prev` = count. No error is counted while in SYNC.
  - TRACK: define expected = `prev` + 1, truncated to WIDTH bits.
    - Match: increment `good_run` (saturate at LOCK_THRESH). Assert `locked` once `good_run` reaches LOCK_THRESH. If expected = 0, pulse `wrap_pulse` and increment `wrap_cnt`.
    - Mismatch: pulse `err_pulse`, increment `err_cnt`, and set `good_run` = 0 and `locked` = 0. Resync with `prev` = count and stay in TRACK. If `err_sticky` was 0, capture `err_expected`/`err_actual` and set `err_sticky`.
  - `prev` updates to `count` on every sample while `en` = 1.
- `en` = 0 in any state: next state is IDLE, `locked` = 0, pulses are 0, statistics and the capture hold their values.
- Statistics saturate at 2^STAT_W − 1; they never wrap.
- `clear`: zeroes `wrap_cnt`, `err_cnt`, `err_sticky`, `err_expected` and `err_actual`. It does not affect state, `prev` or `locked`.
- `clear` and an event in the same cycle: the clear applies first, then the event is recorded. For example, an error gives `err_cnt` = 1, `err_sticky` = 1 and a fresh capture.
- A hold (count = `prev`) is a mismatch unless the optional feature is enabled.

Optional Feature:
- Macro: COUNT_SEQ_HOLD_EN.
- Defined: count = `prev` in TRACK is accepted as a stall. No error is raised, `good_run` is unchanged, `prev` is unchanged and no wrap is counted. Supports an upstream counter with a clock enable.
- Undefined: a hold is treated as an ordinary mismatch.

Decomposition:
- Shared include/package `count_pkg`: state encodings (IDLE = 2'd0, SYNC = 2'd1, TRACK = 2'd2) and default width constants reused by the counter and its benches.
- One sub-module, `sat_counter` (parameter W; inputs clr and inc; output value), instantiated twice for `wrap_cnt` and `err_cnt`.

Test Plan:
- Release reset with `en` = 1 and counter free-running 0,1,2,… → SYNC then TRACK, `locked` = 1 after the 3rd good step, `err_cnt` = 0.
- 40 clean cycles with WIDTH = 4 → `wrap_pulse` exactly on the 15→0 steps (2 times), `wrap_cnt` = 2, no `err_pulse`.
- Inject count 5→9 in TRACK → `err_pulse` for 1 cycle, `err_expected` = 6, `err_actual` = 9, `err_sticky` = 1, `locked` = 0. The 9→10 step that follows is a good step.
- Second error 12→3 → `err_cnt` = 2, capture still 6/9. Then `clear` in the same cycle as a third error → `err_cnt` = 1, capture shows the third error.
- Force 300 errors with STAT_W = 8 → `err_cnt` holds at 255. Reset mid-run → all outputs 0 on the next edge, state IDLE.
- With COUNT_SEQ_HOLD_EN defined, count 7,7,7,8 → no error, `locked` unchanged. Without the macro → 2 errors on the same sequence.
